// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control/status bundle between the multi-cycle controller and its datapath.
interface multicycle_control_if #(parameter int INSTRET_W = 32);
   logic [31:0]          instr;
   logic [4:0]           status;
   logic                 pcsrc;
   logic                 alusrc;
   logic [3:0]           aluop;
   logic                 memrw;
   logic                 wb;
   logic                 regrw;
   logic [1:0]           immgen_ctrl;
   logic                 pc_en;
   logic                 illegal;
   logic [INSTRET_W-1:0] instret;
   modport master (output instr, status,
                   input pcsrc, alusrc, aluop, memrw, wb, regrw, immgen_ctrl, pc_en, illegal, instret);
   modport slave (input instr, status,
                  output pcsrc, alusrc, aluop, memrw, wb, regrw, immgen_ctrl, pc_en, illegal, instret);
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH-DECODE-EXEC-MEM-WB sequencer with decode, branch resolution and retire count.
module multicycle_control #(parameter int INSTRET_W = 32) (
   input logic clk,
   input logic rst,
   multicycle_control_if.slave bus
);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
   typedef enum logic [1:0] {K_RI, K_LW, K_SW, K_BR} kind_t;
   state_t               state;
   kind_t                kind, kind_d;
   logic [6:0]           op, f7;
   logic [2:0]           f3;
   logic [3:0]           base, alu_d, aluop;
   logic [1:0]           imm_d, immgen_ctrl;
   logic                 f3_ok, legal_d, alusrc_d, wb_d, taken;
   logic                 alusrc, memrw, wb, regrw, pc_en, illegal;
   logic [INSTRET_W-1:0] instret;
   logic                 unused_bits;
   assign unused_bits = ^{bus.status[4], bus.instr[24:15], bus.instr[11:7]};
   always_comb begin
      f3_ok = 1'b1;
      case (f3)
         3'b000:  base = 4'b0000;
         3'b100:  base = 4'b0001;
         3'b111:  base = 4'b0010;
         3'b110:  base = 4'b0011;
         3'b001:  base = 4'b0101;
         3'b101:  base = 4'b0110;
         default: begin base = 4'b0000; f3_ok = 1'b0; end
      endcase
      legal_d = 1'b0;
      alu_d = 4'b0000;
      alusrc_d = 1'b0;
      imm_d = 2'b00;
      wb_d = 1'b0;
      kind_d = K_RI;
      case (op)
         7'b0110011: begin
            legal_d = f3_ok && (f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b110)));
            alu_d = f7[5] ? (f3 == 3'b000 ? 4'b0111 : 4'b0100) : base;
         end
         7'b0010011: begin
            legal_d = f3_ok && (f3[1:0] != 2'b01 || f7 == 7'd0);
            alu_d = base;
            alusrc_d = 1'b1;
         end
         7'b0000011: begin
            legal_d = f3 == 3'b010;
            alusrc_d = 1'b1;
            wb_d = 1'b1;
            kind_d = K_LW;
         end
         7'b0100011: begin
            legal_d = f3 == 3'b010;
            alusrc_d = 1'b1;
            imm_d = 2'b01;
            kind_d = K_SW;
         end
         7'b1100011: begin
            legal_d = !f3[1];
            alu_d = 4'b0111;
            imm_d = 2'b10;
            kind_d = K_BR;
         end
         default: legal_d = 1'b0;
      endcase
   end
   // Flags only settle during EXEC, so the branch decision is resolved combinationally there.
   assign taken = (f3[2] ? bus.status[1] ^ bus.status[3] : bus.status[0]) ^ f3[0];
   assign bus.pcsrc = state == EXEC && kind == K_BR && taken;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         kind <= K_RI;
         {f7, f3, op} <= '0;
         {alusrc, aluop, immgen_ctrl, wb} <= '0;
         {memrw, regrw, pc_en, illegal} <= '0;
         instret <= '0;
      end else begin
         regrw <= 1'b0;
         memrw <= 1'b0;
         pc_en <= 1'b0;
         instret <= instret + INSTRET_W'(pc_en);
         case (state)
            IDLE:   state <= FETCH;
            FETCH: begin
               {f7, f3, op} <= {bus.instr[31:25], bus.instr[14:12], bus.instr[6:0]};
               state <= DECODE;
            end
            DECODE: if (!legal_d) begin
               illegal <= 1'b1;
               state <= TRAP;
            end else begin
               {alusrc, aluop, immgen_ctrl, wb} <= {alusrc_d, alu_d, imm_d, wb_d};
               kind <= kind_d;
               pc_en <= kind_d == K_BR;
               state <= EXEC;
            end
            EXEC: begin
               state <= kind == K_BR ? FETCH : (kind == K_RI ? WB : MEM);
               memrw <= kind == K_SW;
               regrw <= kind == K_RI;
               pc_en <= kind == K_RI || kind == K_SW;
            end
            MEM: begin
               state <= kind == K_LW ? WB : FETCH;
               regrw <= kind == K_LW;
               pc_en <= kind == K_LW;
            end
            WB:     state <= FETCH;
            default: state <= TRAP;
         endcase
      end
   end
   assign bus.alusrc = alusrc;
   assign bus.aluop = aluop;
   assign bus.memrw = memrw;
   assign bus.wb = wb;
   assign bus.regrw = regrw;
   assign bus.immgen_ctrl = immgen_ctrl;
   assign bus.pc_en = pc_en;
   assign bus.illegal = illegal;
   assign bus.instret = instret;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed per-feature tests of the multi-cycle controller.
module tb_multicycle_control;
   localparam logic [31:0] ADD  = 32'h00B50533;
   localparam logic [31:0] SUB  = 32'h40B50533;
   localparam logic [31:0] NOR  = 32'h40B56533;
   localparam logic [31:0] ADDI = 32'h00150513;
   localparam logic [31:0] LW   = 32'h0042A303;
   localparam logic [31:0] SW   = 32'h0062A223;
   localparam logic [31:0] BEQ  = 32'h00B50463;
   localparam logic [31:0] BNE  = 32'h00B51463;
   localparam logic [31:0] BLT  = 32'h00B54463;
   localparam logic [31:0] BAD  = 32'hFFFFFFFF;
   localparam logic [31:0] BADR = 32'h40B54533;
   logic clk = 1'b0;
   logic rst;
   int passed = 0;
   int total = 0;
   multicycle_control_if #(.INSTRET_W(32)) bus();
   multicycle_control #(.INSTRET_W(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
   endtask
   task automatic test_reset;
      bus.instr = ADD;
      bus.status = 5'd0;
      rst = 1'b1;
      #1;
      total++;
      if ({bus.pcsrc, bus.alusrc, bus.aluop, bus.memrw, bus.wb, bus.regrw, bus.immgen_ctrl, bus.pc_en, bus.illegal, bus.instret} !== 45'd0)
         $display("FAIL reset_async outputs %h instret %0d exp 0", {bus.pcsrc, bus.alusrc, bus.aluop, bus.memrw, bus.wb, bus.regrw, bus.immgen_ctrl, bus.pc_en, bus.illegal}, bus.instret);
      else passed++;
      repeat (3) tick();
      rst = 1'b0;
      #1;
      total++;
      if ({bus.pcsrc, bus.alusrc, bus.aluop, bus.memrw, bus.wb, bus.regrw, bus.immgen_ctrl, bus.pc_en, bus.illegal, bus.instret} !== 45'd0)
         $display("FAIL reset_idle outputs %h instret %0d exp 0", {bus.pcsrc, bus.alusrc, bus.aluop, bus.memrw, bus.wb, bus.regrw, bus.immgen_ctrl, bus.pc_en, bus.illegal}, bus.instret);
      else passed++;
   endtask
   task automatic test_add;
      logic [3:0] exp [1:5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0011, 4'b0000};
      for (int k = 1; k <= 5; k++) begin
         tick();
         total++;
         if ({bus.pcsrc, bus.memrw, bus.regrw, bus.pc_en} !== exp[k])
            $display("FAIL add_strobes cyc%0d got %b exp %b", k, {bus.pcsrc, bus.memrw, bus.regrw, bus.pc_en}, exp[k]);
         else passed++;
         if (k == 3 || k == 4) begin
            total++;
            if ({bus.alusrc, bus.aluop, bus.immgen_ctrl, bus.wb} !== 8'b0_0000_00_0)
               $display("FAIL add_ctrl cyc%0d got %b exp 00000000", k, {bus.alusrc, bus.aluop, bus.immgen_ctrl, bus.wb});
            else passed++;
         end
         if (k == 4) begin
            total++;
            if (bus.instret !== 32'd0) $display("FAIL add_instret_pre got %0d exp 0", bus.instret);
            else passed++;
         end
      end
      total++;
      if (bus.instret !== 32'd1) $display("FAIL add_instret got %0d exp 1", bus.instret);
      else passed++;
   endtask
   task automatic test_lw;
      logic [3:0] exp [1:6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 4'b0000};
      do_reset();
      bus.instr = LW;
      for (int k = 1; k <= 6; k++) begin
         tick();
         total++;
         if ({bus.pcsrc, bus.memrw, bus.regrw, bus.pc_en} !== exp[k])
            $display("FAIL lw_strobes cyc%0d got %b exp %b", k, {bus.pcsrc, bus.memrw, bus.regrw, bus.pc_en}, exp[k]);
         else passed++;
         if (k >= 3 && k <= 5) begin
            total++;
            if ({bus.alusrc, bus.aluop, bus.immgen_ctrl, bus.wb} !== 8'b1_0000_00_1)
               $display("FAIL lw_ctrl cyc%0d got %b exp 10000001", k, {bus.alusrc, bus.aluop, bus.immgen_ctrl, bus.wb});
            else passed++;
         end
      end
      total++;
      if (bus.instret !== 32'd1) $display("FAIL lw_instret got %0d exp 1", bus.instret);
      else passed++;
   endtask
   task automatic test_sw;
      logic [3:0] exp [1:5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0101, 4'b0000};
      do_reset();
      bus.instr = SW;
      for (int k = 1; k <= 5; k++) begin
         tick();
         total++;
         if ({bus.pcsrc, bus.memrw, bus.regrw, bus.pc_en} !== exp[k])
            $display("FAIL sw_strobes cyc%0d got %b exp %b", k, {bus.pcsrc, bus.memrw, bus.regrw, bus.pc_en}, exp[k]);
         else passed++;
         if (k == 3 || k == 4) begin
            total++;
            if ({bus.alusrc, bus.aluop, bus.immgen_ctrl, bus.wb} !== 8'b1_0000_01_0)
               $display("FAIL sw_ctrl cyc%0d got %b exp 10000010", k, {bus.alusrc, bus.aluop, bus.immgen_ctrl, bus.wb});
            else passed++;
         end
      end
      total++;
      if (bus.instret !== 32'd1) $display("FAIL sw_instret got %0d exp 1", bus.instret);
      else passed++;
   endtask
   task automatic test_back_to_back;
      logic [31:0] prog [3] = '{SUB, NOR, ADDI};
      logic [6:0]  ctl [3] = '{7'b0_0111_00, 7'b0_0100_00, 7'b1_0000_00};
      do_reset();
      bus.instr = prog[0];
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         bus.instr = prog[(i + 1) % 3];
         tick();
         total++;
         if ({bus.alusrc, bus.aluop, bus.immgen_ctrl} !== ctl[i])
            $display("FAIL b2b_ctrl instr%0d got %b exp %b", i, {bus.alusrc, bus.aluop, bus.immgen_ctrl}, ctl[i]);
         else passed++;
         tick();
         total++;
         if ({bus.pcsrc, bus.memrw, bus.regrw, bus.pc_en} !== 4'b0011)
            $display("FAIL b2b_wb instr%0d got %b exp 0011", i, {bus.pcsrc, bus.memrw, bus.regrw, bus.pc_en});
         else passed++;
         tick();
      end
      total++;
      if (bus.instret !== 32'd3) $display("FAIL b2b_instret got %0d exp 3", bus.instret);
      else passed++;
   endtask
   task automatic test_branch;
      logic [3:0] exp [1:7] = '{4'b0000, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
      do_reset();
      bus.instr = BEQ;
      bus.status = 5'b00001;
      for (int k = 1; k <= 7; k++) begin
         if (k == 6) bus.status = 5'b00000;
         tick();
         total++;
         if ({bus.pcsrc, bus.memrw, bus.regrw, bus.pc_en} !== exp[k])
            $display("FAIL beq_strobes cyc%0d got %b exp %b", k, {bus.pcsrc, bus.memrw, bus.regrw, bus.pc_en}, exp[k]);
         else passed++;
         if (k == 3) begin
            total++;
            if ({bus.alusrc, bus.aluop, bus.immgen_ctrl, bus.wb} !== 8'b0_0111_10_0)
               $display("FAIL beq_ctrl got %b exp 00111100", {bus.alusrc, bus.aluop, bus.immgen_ctrl, bus.wb});
            else passed++;
         end
      end
      total++;
      if (bus.instret !== 32'd2) $display("FAIL beq_instret got %0d exp 2", bus.instret);
      else passed++;
   endtask
   task automatic test_branch_conds;
      do_reset();
      bus.instr = BNE;
      bus.status = 5'b00001;
      repeat (3) tick();
      total++;
      if ({bus.pcsrc, bus.pc_en} !== 2'b01)
         $display("FAIL bne_z got pcsrc/pc_en %b exp 01", {bus.pcsrc, bus.pc_en});
      else passed++;
      bus.instr = BLT;
      bus.status = 5'b10010;
      repeat (3) tick();
      total++;
      if ({bus.pcsrc, bus.pc_en} !== 2'b11)
         $display("FAIL blt_n got pcsrc/pc_en %b exp 11", {bus.pcsrc, bus.pc_en});
      else passed++;
      bus.status = 5'b01010;
      #1;
      total++;
      if ({bus.pcsrc, bus.pc_en} !== 2'b01)
         $display("FAIL blt_nv got pcsrc/pc_en %b exp 01", {bus.pcsrc, bus.pc_en});
      else passed++;
      bus.status = 5'd0;
   endtask
   task automatic test_illegal;
      do_reset();
      bus.instr = BAD;
      repeat (2) tick();
      total++;
      if (bus.illegal !== 1'b0) $display("FAIL illegal_early got %b exp 0", bus.illegal);
      else passed++;
      tick();
      bus.instr = ADD;
      total++;
      if (bus.illegal !== 1'b1) $display("FAIL illegal_set got %b exp 1", bus.illegal);
      else passed++;
      for (int k = 0; k < 20; k++) begin
         tick();
         total++;
         if ({bus.pcsrc, bus.memrw, bus.regrw, bus.pc_en, bus.illegal} !== 5'b00001)
            $display("FAIL illegal_hold cyc%0d got %b exp 00001", k, {bus.pcsrc, bus.memrw, bus.regrw, bus.pc_en, bus.illegal});
         else passed++;
      end
      total++;
      if (bus.instret !== 32'd0) $display("FAIL illegal_instret got %0d exp 0", bus.instret);
      else passed++;
      rst = 1'b1;
      #1;
      total++;
      if (bus.illegal !== 1'b0) $display("FAIL illegal_clear got %b exp 0", bus.illegal);
      else passed++;
      do_reset();
      bus.instr = BADR;
      repeat (3) tick();
      total++;
      if (bus.illegal !== 1'b1) $display("FAIL illegal_rfunct7 got %b exp 1", bus.illegal);
      else passed++;
   endtask
   task automatic test_reset_mid;
      do_reset();
      bus.instr = ADD;
      repeat (2) tick();
      bus.instr = SW;
      repeat (6) tick();
      total++;
      if ({bus.memrw, bus.instret} !== {1'b1, 32'd1})
         $display("FAIL mid_pre memrw %b instret %0d exp 1 1", bus.memrw, bus.instret);
      else passed++;
      #2;
      rst = 1'b1;
      #1;
      total++;
      if ({bus.pcsrc, bus.alusrc, bus.aluop, bus.memrw, bus.wb, bus.regrw, bus.immgen_ctrl, bus.pc_en, bus.illegal, bus.instret} !== 45'd0)
         $display("FAIL mid_async outputs %h instret %0d exp 0", {bus.pcsrc, bus.alusrc, bus.aluop, bus.memrw, bus.wb, bus.regrw, bus.immgen_ctrl, bus.pc_en, bus.illegal}, bus.instret);
      else passed++;
      for (int k = 0; k < 2; k++) begin
         tick();
         total++;
         if ({bus.memrw, bus.pc_en, bus.instret} !== 34'd0)
            $display("FAIL mid_hold cyc%0d memrw %b pc_en %b instret %0d exp 0", k, bus.memrw, bus.pc_en, bus.instret);
         else passed++;
      end
      rst = 1'b0;
      bus.instr = ADD;
      repeat (4) tick();
      total++;
      if (bus.pc_en !== 1'b1) $display("FAIL mid_resume pc_en got %b exp 1", bus.pc_en);
      else passed++;
   endtask
   initial begin
      test_reset();
      test_add();
      test_lw();
      test_sw();
      test_back_to_back();
      test_branch();
      test_branch_conds();
      test_illegal();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
